sal_wr_arb: RTL and testbench
=============================

Name: sal_wr_arb

Overview:
- Arbitrates write column commands from NUM_BANKS bank controllers onto the single write datapath of the DDR controller.
- Issues at most one write grant at a time, using a rotating-priority (round-robin) pointer.
- A grant is issued only when the column-to-column (tCCD) and read-to-write (tRTW) timing counters have expired, and only when the W-data buffer holds enough beats to cover the burst.
- Drives the write-grant strobe that starts the DFI write-enable pipeline.

Parameters:
- NUM_BANKS, 4, number of requesting bank controllers.
- CNT_WIDTH, 4, width of timing inputs and timing counters.
- BEATS_PER_WR, 2, W-buffer beats consumed by one write grant.
- BUF_DEPTH, 8, W-buffer capacity in beats; sets the credit ceiling.
- CRD_WIDTH, 4, credit counter width; must be ≥ clog2(BUF_DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, single clock domain.
- req_i  in  NUM_BANKS  per-bank write request; held high until granted.
- gnt_o  out  NUM_BANKS  one-hot grant, one-cycle pulse.
- wr_gnt_o  out  1  OR of gnt_o; drives the write-control grant strobe.
- wr_ba_o  out  clog2(NUM_BANKS)  index of the granted bank; valid when wr_gnt_o=1.
- w_push_i  in  1  one W beat accepted into the write buffer this cycle (wvalid & wready).
- rd_gnt_i  in  1  read column command issued this cycle.
- t_ccd_i  in  CNT_WIDTH  tCCD in cycles; quasi-static.
- t_rtw_i  in  CNT_WIDTH  read-to-write turnaround in cycles; quasi-static.
- credits_o  out  CRD_WIDTH  buffered beats not yet claimed by a grant.
- ovf_err_o  out  1  sticky error: a beat was pushed while credits == BUF_DEPTH.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - ccd_cnt = 0, rtw_cnt = 0, credits = 0;
  - round-robin pointer rr_ptr = 0;
  - ovf_err_o = 0.
  - All outputs are therefore 0. A request in flight when reset arrives is dropped; the requester must re-request.
- Eligibility (combinational from state and inputs): eligible = (ccd_cnt == 0) & (rtw_cnt == 0) & (credits ≥ BEATS_PER_WR) & ~rd_gnt_i. Reads win a same-cycle collision.
- Selection:
  - When eligible and any req_i is high, grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_BANKS.
  - gnt_o, wr_gnt_o and wr_ba_o are combinational, with zero-cycle latency from req_i.
- On a grant of bank k:
  - rr_ptr <= (k+1) mod NUM_BANKS; pointer wrap-around is required.
  - ccd_cnt <= max(t_ccd_i, 2) - 1. This enforces a minimum 2-cycle spacing, matching the 2-cycle write-enable burst.
- On rd_gnt_i: rtw_cnt <= t_rtw_i, saturating to 0 if t_rtw_i = 0.
- Otherwise each nonzero counter decrements by 1 per cycle.
- Credits: next = credits + w_push_i - (grant ? BEATS_PER_WR : 0). A simultaneous push and grant nets to +1 - BEATS_PER_WR; underflow is impossible by eligibility.
- Overflow: a push with credits == BUF_DEPTH and no grant in the same cycle:
  - credits holds at BUF_DEPTH;
  - ovf_err_o is set and stays high until reset.
- No state machine beyond the counters. Effective phases are:
  - IDLE (no req);
  - BLOCKED (a timer is running or credits are short);
  - GRANT.
- Requester protocol: the requester drops req the cycle after its gnt. If req is still high, it is treated as a new request, which the ccd_cnt blocking window throttles.

Decomposition:
- Package sal_wr_arb_pkg holds:
  - BEATS_PER_WR and BUF_DEPTH defaults;
  - function clog2;
  - function rr_pick(req, ptr), returning a one-hot grant and an index.
- One natural sub-module: sal_rr_arbiter. It contains the pure round-robin picker plus the pointer register, and is reusable by the read arbiter.

Test Plan:
- Reset, then 3 pushes and req_i=4'b0001 → no grant after 1 push; grant to bank 0 once credits=2; credits_o then 0 and later 1 after the 3rd push.
- credits=8, t_ccd_i=4, req_i=4'b1111 held → grants to banks 0,1,2,3 exactly 4 cycles apart; pointer wraps back to 0.
- t_ccd_i=1 with back-to-back eligibility → grants exactly 2 cycles apart.
- rd_gnt_i pulse, t_rtw_i=5, req pending and credits OK → no write grant in that cycle or the next 5; grant on the 6th cycle.
- Same-cycle rd_gnt_i and eligible write → no write grant; rtw_cnt loaded.
- 9 pushes with no requests → credits_o saturates at 8 and ovf_err_o=1; rst asserted mid-burst → all outputs 0 the next cycle.

Source files
------------

// File: rtl/sal_wr_arb_pkg.sv
// Shared types and helpers for the write-column arbiter and its round-robin picker.
package sal_wr_arb_pkg;

    localparam int NUM_BANKS_DEF    = 4;
    localparam int BEATS_PER_WR_DEF = 2;
    localparam int BUF_DEPTH_DEF    = 8;

    // Widest request vector the generic picker handles; callers zero-extend.
    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_MAX-1:0]   gnt;
    } rr_pick_t;

    // Ceiling log2 for elaboration-time widths: counts powers of two below value.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            res = res + ((value > (32'sd1 <<< i)) ? 32'sd1 : 32'sd0);
        end
        return res;
    endfunction

    // First set request at or above ptr, wrapping modulo n; one-hot plus index.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  n);
        rr_pick_t res;
        int       pos;
        res = '0;
        for (int off = 0; off < RR_MAX; off++) begin
            pos = (int'(ptr) + off) % n;
            if ((off < n) && !res.valid && req[pos]) begin
                res.valid    = 1'b1;
                res.idx      = RR_IDX_W'(pos);
                res.gnt[pos] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sal_wr_arb_rr_arbiter.sv
// Round-robin picker with its rotating pointer; shared by the read and write arbiters.
module sal_rr_arbiter
    import sal_wr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic             gnt_any,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0]  ptr_r;
    logic [RR_MAX-1:0] req_ext_s;
    rr_pick_t          pick_s;
    logic              unused_s;

    // Upper picker bits are structurally zero for N below RR_MAX.
    assign unused_s = ^{pick_s.gnt[RR_MAX-1:N], pick_s.idx[RR_IDX_W-1:IDX_W]};

    // Pick the next requester from the pointer; suppress everything while not enabled.
    always_comb begin
        req_ext_s        = '0;
        req_ext_s[N-1:0] = req;
        pick_s           = rr_pick(req_ext_s, RR_IDX_W'(ptr_r), N);
        if (en && pick_s.valid) begin
            gnt     = pick_s.gnt[N-1:0];
            gnt_any = 1'b1;
            gnt_idx = pick_s.idx[IDX_W-1:0];
        end else begin
            gnt     = '0;
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
    end

    // Move the pointer just past the winner so it has lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (gnt_any) begin
            ptr_r <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/sal_wr_arb.sv
// Write-column arbiter: round-robin over bank controllers, gated by tCCD/tRTW and W-buffer credits.
module sal_wr_arb
    import sal_wr_arb_pkg::*;
#(
    parameter int NUM_BANKS    = NUM_BANKS_DEF,
    parameter int CNT_WIDTH    = 4,
    parameter int BEATS_PER_WR = BEATS_PER_WR_DEF,
    parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
    parameter int CRD_WIDTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BANKS-1:0]          req_i,
    output logic [NUM_BANKS-1:0]          gnt_o,
    output logic                          wr_gnt_o,
    output logic [clog2(NUM_BANKS)-1:0]   wr_ba_o,
    input  logic                          w_push_i,
    input  logic                          rd_gnt_i,
    input  logic [CNT_WIDTH-1:0]          t_ccd_i,
    input  logic [CNT_WIDTH-1:0]          t_rtw_i,
    output logic [CRD_WIDTH-1:0]          credits_o,
    output logic                          ovf_err_o
);

    localparam int BA_W = clog2(NUM_BANKS);

    logic [CNT_WIDTH-1:0] ccd_cnt_r;
    logic [CNT_WIDTH-1:0] rtw_cnt_r;
    logic [CRD_WIDTH-1:0] credits_r;
    logic                 ovf_r;

    logic                 elig_s;
    logic [NUM_BANKS-1:0] gnt_s;
    logic                 gnt_any_s;
    logic [BA_W-1:0]      gnt_idx_s;
    logic [CNT_WIDTH-1:0] ccd_load_s;
    logic                 ovf_hit_s;
    logic [CRD_WIDTH-1:0] credits_nxt_s;

    // A read command in the same cycle always wins over a write.
    assign elig_s = (ccd_cnt_r == '0) && (rtw_cnt_r == '0) &&
                    (credits_r >= CRD_WIDTH'(BEATS_PER_WR)) && !rd_gnt_i;

    sal_rr_arbiter #(
        .N     (NUM_BANKS),
        .IDX_W (BA_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_i),
        .en      (elig_s),
        .gnt     (gnt_s),
        .gnt_any (gnt_any_s),
        .gnt_idx (gnt_idx_s)
    );

    assign gnt_o     = gnt_s;
    assign wr_gnt_o  = gnt_any_s;
    assign wr_ba_o   = gnt_idx_s;
    assign credits_o = credits_r;
    assign ovf_err_o = ovf_r;

    // Column spacing never drops below the 2-cycle write-enable burst.
    assign ccd_load_s = (t_ccd_i < CNT_WIDTH'(2)) ? CNT_WIDTH'(1) : t_ccd_i - CNT_WIDTH'(1);

    // Credit bookkeeping: a push into a full buffer with no grant is an overflow and is dropped.
    always_comb begin
        ovf_hit_s     = w_push_i && (credits_r == CRD_WIDTH'(BUF_DEPTH)) && !gnt_any_s;
        credits_nxt_s = credits_r;
        if (ovf_hit_s) begin
            credits_nxt_s = credits_r;
        end else begin
            credits_nxt_s = credits_r + CRD_WIDTH'(w_push_i)
                          - (gnt_any_s ? CRD_WIDTH'(BEATS_PER_WR) : CRD_WIDTH'(0));
        end
    end

    // Column-to-column timer: reloaded on every write grant, otherwise counts down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccd_cnt_r <= '0;
        end else if (gnt_any_s) begin
            ccd_cnt_r <= ccd_load_s;
        end else if (ccd_cnt_r != '0) begin
            ccd_cnt_r <= ccd_cnt_r - CNT_WIDTH'(1);
        end else begin
            ccd_cnt_r <= ccd_cnt_r;
        end
    end

    // Read-to-write turnaround timer: reloaded on every read command.
    always_ff @(posedge clk) begin
        if (rst) begin
            rtw_cnt_r <= '0;
        end else if (rd_gnt_i) begin
            rtw_cnt_r <= t_rtw_i;
        end else if (rtw_cnt_r != '0) begin
            rtw_cnt_r <= rtw_cnt_r - CNT_WIDTH'(1);
        end else begin
            rtw_cnt_r <= rtw_cnt_r;
        end
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r <= '0;
            ovf_r     <= 1'b0;
        end else begin
            credits_r <= credits_nxt_s;
            ovf_r     <= ovf_r | ovf_hit_s;
        end
    end

endmodule

// File: tb/tb_sal_wr_arb.sv
// Self-checking bench for sal_wr_arb: directed scenarios plus randomized traffic against a timestamp model.
module tb_sal_wr_arb;

    localparam int NB  = 4;
    localparam int BPW = 2;
    localparam int BD  = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic       wr_gnt_o;
    logic [1:0] wr_ba_o;
    logic       w_push_i;
    logic       rd_gnt_i;
    logic [3:0] t_ccd_i;
    logic [3:0] t_rtw_i;
    logic [3:0] credits_o;
    logic       ovf_err_o;

    sal_wr_arb #(
        .NUM_BANKS(4), .CNT_WIDTH(4), .BEATS_PER_WR(2), .BUF_DEPTH(8), .CRD_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .wr_gnt_o(wr_gnt_o),
        .wr_ba_o(wr_ba_o), .w_push_i(w_push_i), .rd_gnt_i(rd_gnt_i),
        .t_ccd_i(t_ccd_i), .t_rtw_i(t_rtw_i), .credits_o(credits_o), .ovf_err_o(ovf_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the cycle number at which each timing constraint clears.
    int m_cyc, m_ccd_ready, m_rtw_ready, m_cr, m_ptr;
    bit m_ovf;

    logic [3:0] exp_gnt;
    bit         exp_any;
    int         exp_idx, exp_cr;
    bit         exp_ovf;

    logic [3:0] obs_gnt;
    logic       obs_wr;
    logic [1:0] obs_ba;
    logic [3:0] obs_cr;
    logic       obs_ovf;

    task automatic do_reset(input logic [3:0] r, input bit p);
        req_i = r; w_push_i = p; rd_gnt_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cyc = 0; m_ccd_ready = 0; m_rtw_ready = 0; m_cr = 0; m_ptr = 0; m_ovf = 0;
    endtask

    // Drive one cycle, compute model outputs, sample DUT, advance model across the edge.
    task automatic tick(input logic [3:0] r, input bit p, input bit rg);
        bit elig;
        int pos;
        req_i = r; w_push_i = p; rd_gnt_i = rg;
        #1;
        elig = (m_cyc >= m_ccd_ready) && (m_cyc >= m_rtw_ready) && (m_cr >= BPW) && !rg;
        exp_gnt = 4'b0000; exp_any = 0; exp_idx = 0;
        if (elig) begin
            for (int k = 0; k < NB; k++) begin
                pos = (m_ptr + k) % NB;
                if (!exp_any && r[pos]) begin
                    exp_any = 1; exp_idx = pos; exp_gnt[pos] = 1'b1;
                end
            end
        end
        exp_cr = m_cr; exp_ovf = m_ovf;
        obs_gnt = gnt_o; obs_wr = wr_gnt_o; obs_ba = wr_ba_o; obs_cr = credits_o; obs_ovf = ovf_err_o;
        @(posedge clk);
        if (exp_any) begin
            m_ptr = (exp_idx + 1) % NB;
            m_ccd_ready = m_cyc + ((t_ccd_i < 4'd2) ? 2 : int'(t_ccd_i));
        end
        if (rg) m_rtw_ready = m_cyc + int'(t_rtw_i) + 1;
        if (p && m_cr == BD && !exp_any) m_ovf = 1;
        else m_cr = m_cr + int'(p) - (exp_any ? BPW : 0);
        m_cyc++;
        #1;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) tick(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset(4'b0000, 1'b0);
        tick(4'b1111, 1'b0, 1'b0);
        n_cmp++; if (obs_gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", obs_gnt); end
        n_cmp++; if (obs_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got=%b exp=0", obs_wr); end
        n_cmp++; if (obs_cr !== 4'd0) begin n_err++; $display("FAIL reset_credits got=%0d exp=0", obs_cr); end
        n_cmp++; if (obs_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", obs_ovf); end
    endtask

    task automatic test_credit_gate();
        do_reset(4'b0000, 1'b0);
        t_ccd_i = 4'd1; t_rtw_i = 4'd0;
        tick(4'b0001, 1'b1, 1'b0);
        n_cmp++; if (obs_gnt !== 4'b0000) begin n_err++; $display("FAIL crd_no_gnt0 got=%b exp=0000", obs_gnt); end
        tick(4'b0001, 1'b1, 1'b0);
        n_cmp++; if (obs_gnt !== 4'b0000) begin n_err++; $display("FAIL crd_no_gnt1 got=%b exp=0000", obs_gnt); end
        n_cmp++; if (obs_cr !== 4'd1) begin n_err++; $display("FAIL crd_one got=%0d exp=1", obs_cr); end
        tick(4'b0001, 1'b0, 1'b0);
        n_cmp++; if (obs_gnt !== 4'b0001) begin n_err++; $display("FAIL crd_gnt got=%b exp=0001", obs_gnt); end
        n_cmp++; if (obs_wr !== 1'b1 || obs_ba !== 2'd0) begin n_err++; $display("FAIL crd_wr_ba got=%b/%0d exp=1/0", obs_wr, obs_ba); end
        n_cmp++; if (obs_cr !== 4'd2) begin n_err++; $display("FAIL crd_two got=%0d exp=2", obs_cr); end
        tick(4'b0000, 1'b1, 1'b0);
        n_cmp++; if (obs_cr !== 4'd0) begin n_err++; $display("FAIL crd_after_gnt got=%0d exp=0", obs_cr); end
        tick(4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs_cr !== 4'd1) begin n_err++; $display("FAIL crd_third_push got=%0d exp=1", obs_cr); end
    endtask

    task automatic test_rr_wrap();
        int offs[$];
        int banks[$];
        int b;
        do_reset(4'b0000, 1'b0);
        t_ccd_i = 4'd4; t_rtw_i = 4'd0;
        preload(8);
        for (int o = 0; o <= 16; o++) begin
            tick(4'b1111, (o % 4 == 0) || (o % 4 == 2), 1'b0);
            n_cmp++; if (obs_gnt !== exp_gnt) begin n_err++; $display("FAIL rr_model o=%0d got=%b exp=%b", o, obs_gnt, exp_gnt); end
            if (obs_wr) begin
                b = -1;
                for (int k = 0; k < NB; k++) if (obs_gnt[k]) b = k;
                offs.push_back(o); banks.push_back(b);
            end
        end
        n_cmp++; if (offs.size() != 5) begin n_err++; $display("FAIL rr_count got=%0d exp=5", offs.size()); end
        for (int i = 0; i < offs.size() && i < 5; i++) begin
            n_cmp++;
            if (offs[i] != 4 * i || banks[i] != i % NB) begin
                n_err++; $display("FAIL rr_seq i=%0d got=off%0d/bank%0d exp=off%0d/bank%0d", i, offs[i], banks[i], 4 * i, i % NB);
            end
        end
    endtask

    task automatic test_back_to_back();
        int offs[$];
        do_reset(4'b0000, 1'b0);
        t_ccd_i = 4'd1; t_rtw_i = 4'd0;
        preload(8);
        for (int o = 0; o < 9; o++) begin
            tick(4'b1111, 1'b0, 1'b0);
            if (obs_wr) offs.push_back(o);
        end
        n_cmp++; if (offs.size() != 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", offs.size()); end
        for (int i = 0; i < offs.size() && i < 4; i++) begin
            n_cmp++; if (offs[i] != 2 * i) begin n_err++; $display("FAIL b2b_spacing i=%0d got=%0d exp=%0d", i, offs[i], 2 * i); end
        end
    endtask

    task automatic test_rtw();
        do_reset(4'b0000, 1'b0);
        t_ccd_i = 4'd1; t_rtw_i = 4'd5;
        preload(2);
        for (int i = 0; i <= 6; i++) begin
            tick(4'b0010, 1'b0, (i == 0));
            if (i < 6) begin
                n_cmp++; if (obs_wr !== 1'b0) begin n_err++; $display("FAIL rtw_block i=%0d got=%b exp=0", i, obs_wr); end
            end else begin
                n_cmp++; if (obs_gnt !== 4'b0010 || obs_ba !== 2'd1) begin n_err++; $display("FAIL rtw_release got=%b/%0d exp=0010/1", obs_gnt, obs_ba); end
            end
        end
    endtask

    task automatic test_collision();
        do_reset(4'b0000, 1'b0);
        t_ccd_i = 4'd1; t_rtw_i = 4'd3;
        preload(2);
        for (int i = 0; i <= 4; i++) begin
            tick(4'b0001, 1'b0, (i == 0));
            n_cmp++; if (obs_wr !== (i == 4)) begin n_err++; $display("FAIL collide i=%0d got=%b exp=%b", i, obs_wr, (i == 4)); end
        end
    endtask

    task automatic test_overflow();
        do_reset(4'b0000, 1'b0);
        preload(9);
        tick(4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs_cr !== 4'd8) begin n_err++; $display("FAIL ovf_sat got=%0d exp=8", obs_cr); end
        n_cmp++; if (obs_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", obs_ovf); end
        preload(2);
        do_reset(4'b1111, 1'b1);
        tick(4'b1111, 1'b0, 1'b0);
        n_cmp++;
        if (obs_gnt !== 4'b0000 || obs_wr !== 1'b0 || obs_ba !== 2'd0 || obs_cr !== 4'd0 || obs_ovf !== 1'b0) begin
            n_err++; $display("FAIL ovf_reset got=%b/%b/%0d/%0d/%b exp=all zero", obs_gnt, obs_wr, obs_ba, obs_cr, obs_ovf);
        end
    endtask

    task automatic test_random();
        logic [3:0] pend, just, r;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(4'b0000, 1'b0);
            t_ccd_i = 4'($urandom_range(0, 6));
            t_rtw_i = 4'($urandom_range(0, 6));
            pend = 4'b0000; just = 4'b0000;
            for (int c = 0; c < 300; c++) begin
                r = pend | (4'($urandom_range(0, 15)) & ~just);
                tick(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
                n_cmp++; if (obs_gnt !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, obs_gnt, exp_gnt); end
                n_cmp++; if (obs_wr !== exp_any) begin n_err++; $display("FAIL rnd_wr c=%0d got=%b exp=%b", c, obs_wr, exp_any); end
                if (exp_any) begin
                    n_cmp++; if (int'(obs_ba) != exp_idx) begin n_err++; $display("FAIL rnd_ba c=%0d got=%0d exp=%0d", c, obs_ba, exp_idx); end
                end
                n_cmp++; if (int'(obs_cr) != exp_cr) begin n_err++; $display("FAIL rnd_credits c=%0d got=%0d exp=%0d", c, obs_cr, exp_cr); end
                n_cmp++; if (obs_ovf !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, obs_ovf, exp_ovf); end
                pend = r & ~exp_gnt;
                just = exp_gnt;
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 4'b0000; w_push_i = 1'b0; rd_gnt_i = 1'b0;
        t_ccd_i = 4'd1; t_rtw_i = 4'd0;
        test_reset();
        test_credit_gate();
        test_rr_wrap();
        test_back_to_back();
        test_rtw();
        test_collision();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
